// File: rtl/alu_shift_seq.sv
// Sequential shift/rotate unit: one bit position per clock under a start/busy/done handshake.
// Results (R/C/Z) are registered on entry to DONE so they are valid while done is high.
module alu_shift_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] B,
  output logic [WIDTH-1:0]   R,
  output logic               C,
  output logic               Z,
  output logic               busy,
  output logic               done
);
  localparam logic [2:0] M_ROL = 3'd0, M_ROR = 3'd1, M_SHL = 3'd2, M_SHR = 3'd3, M_ASR = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2:0]         r_mode;
  logic               r_carry;
  logic [WIDTH-1:0]   r_res;
  logic               r_c;
  logic               r_z;
  logic               r_done;

  logic [WIDTH-1:0]   w_step;
  logic               w_cout;

  always_comb begin
    w_step = r_work;
    w_cout = r_carry;
    case (r_mode)
      M_ROL: begin w_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]}; w_cout = r_work[WIDTH-1]; end
      M_ROR: begin w_step = {r_work[0], r_work[WIDTH-1:1]};       w_cout = r_work[0];       end
      M_SHL: begin w_step = {r_work[WIDTH-2:0], 1'b0};            w_cout = r_work[WIDTH-1]; end
      M_SHR: begin w_step = {1'b0, r_work[WIDTH-1:1]};            w_cout = r_work[0];       end
      M_ASR: begin w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]}; w_cout = r_work[0];       end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work  <= A;
            r_cnt   <= B;
            r_mode  <= mode;
            r_carry <= 1'b0;
            // PASS modes behave as a zero-amount op: straight to DONE with R=A
            if (B != '0 && mode <= M_ASR) begin
              r_state <= S_RUN;
            end else begin
              r_state <= S_DONE;
              r_res   <= A;
              r_c     <= 1'b0;
              r_z     <= (A == '0);
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_work  <= w_step;
          r_carry <= w_cout;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            r_state <= S_DONE;
            r_res   <= w_step;
            r_c     <= w_cout;
            r_z     <= (w_step == '0);
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign R    = r_res;
  assign C    = r_c;
  assign Z    = r_z;
  assign done = r_done;
endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: directed test-plan ops, randomized ops, and a mid-run reset,
// all checked against an arithmetic reference model of the shift/rotate rules.
module tb_alu_shift_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   mode;
  logic [W-1:0] A;
  logic [2:0]   B;
  logic [W-1:0] R;
  logic         C, Z, busy, done;

  int checks   = 0;
  int failures = 0;

  alu_shift_seq #(.WIDTH(W), .SHAMT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .A(A), .B(B),
    .R(R), .C(C), .Z(Z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-amount shift/rotate computed arithmetically.
  task automatic model(input logic [2:0] m, input logic [W-1:0] a, input int b,
                       output logic [W-1:0] r, output logic c);
    logic [2*W-1:0] t;
    r = a;
    c = 1'b0;
    if (m > 3'd4 || b == 0) return;
    case (m)
      3'd0: begin t = {a, a} << b; r = t[2*W-1:W]; c = r[0];     end
      3'd1: begin t = {a, a} >> b; r = t[W-1:0];   c = r[W-1];   end
      3'd2: begin r = a << b;                      c = a[W-b];   end
      3'd3: begin r = a >> b;                      c = a[b-1];   end
      default: begin r = W'($signed(a) >>> b);     c = a[b-1];   end
    endcase
  endtask

  // Issue one op, optionally re-asserting start (with A=FF) during the run,
  // then watch the following cycles for latency, busy length and result.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [W-1:0] a,
                        input logic [2:0] b, input bit dup_start);
    logic [W-1:0] er;
    logic         ec;
    int eff, first_done, n_done, n_busy;
    model(m, a, int'(b), er, ec);
    eff = (m > 3'd4) ? 0 : int'(b);
    @(negedge clk);
    mode = m; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = dup_start;
    A = dup_start ? 8'hFF : W'($urandom);
    B = 3'($urandom);
    mode = 3'($urandom);
    first_done = -1; n_done = 0; n_busy = 0;
    for (int j = 1; j <= eff + 4; j++) begin
      @(negedge clk);
      if (j == 2) start = 1'b0;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = j;
          chk({tag, ".R"}, 32'(R), 32'(er));
          chk({tag, ".C"}, 32'(C), 32'(ec));
          chk({tag, ".Z"}, 32'(Z), 32'(er == '0));
        end
      end
    end
    chk({tag, ".latency"}, 32'(first_done), 32'(eff + 1));
    chk({tag, ".ndone"},   32'(n_done),     32'd1);
    chk({tag, ".nbusy"},   32'(n_busy),     32'(eff + 1));
    chk({tag, ".Rhold"},   32'(R),          32'(er));
  endtask

  initial begin
    logic [W-1:0] sr;
    int n_done;
    rst = 1'b1; start = 1'b0; mode = '0; A = '0; B = '0;
    #12;
    chk("reset.R", 32'(R), 0);
    chk("reset.C", 32'(C), 0);
    chk("reset.Z", 32'(Z), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("rol96_3",  3'd0, 8'h96, 3'd3, 1'b0);
    run_op("asr90_2",  3'd4, 8'h90, 3'd2, 1'b0);
    run_op("ror01_1",  3'd1, 8'h01, 3'd1, 1'b0);
    run_op("shr01_1",  3'd3, 8'h01, 3'd1, 1'b0);
    run_op("shl81_7",  3'd2, 8'h81, 3'd7, 1'b0);
    run_op("rol5c_0",  3'd0, 8'h5C, 3'd0, 1'b0);
    run_op("pass3a_5", 3'd6, 8'h3A, 3'd5, 1'b0);
    run_op("dupstart", 3'd0, 8'h96, 3'd3, 1'b1);

    // Reset mid-run: outputs clear immediately, no done for the aborted op
    @(negedge clk);
    mode = 3'd2; A = 8'hFF; B = 3'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.R", 32'(R), 0);
    chk("midrst.C", 32'(C), 0);
    chk("midrst.Z", 32'(Z), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst.nodone", 32'(n_done), 0);
    run_op("afterrst", 3'd2, 8'hFF, 3'd7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sr = W'($urandom);
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), sr,
             3'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
